// File: rtl/qec_sched_pkg.sv
// Shared types and constants for the decode-round scheduler.
package qec_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      WAIT   = 2'd2,
      REPORT = 2'd3
   } sched_state_t;

   localparam int unsigned STATUS_WIDTH   = 2;
   localparam int unsigned ROUND_ID_WIDTH = 16;

   localparam logic [STATUS_WIDTH-1:0] STATUS_OK       = 2'b00;
   localparam logic [STATUS_WIDTH-1:0] STATUS_DEADLOCK = 2'b01;
   localparam logic [STATUS_WIDTH-1:0] STATUS_TIMEOUT  = 2'b10;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/round_watchdog.sv
// Per-round cycle counter; expired rises after TIMEOUT_CYCLES-1 enabled cycles and saturates.
module round_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             expired_q, expired_d;

   always_comb begin
      count_d   = count_q;
      expired_d = expired_q;
      if (clear) begin
         count_d   = '0;
         expired_d = 1'b0;
      end else if (enable && !expired_q) begin
         count_d   = count_q + CNT_W'(1);
         expired_d = (count_d == LIMIT);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         expired_q <= expired_d;
      end
   end

   assign expired = expired_q;

endmodule

// File: rtl/decoder_round_scheduler.sv
// Sequences decode rounds over the two decoder halves and reports one status record per round.
module decoder_round_scheduler
   import qec_sched_pkg::*;
#(
   parameter int unsigned CODE_DISTANCE_X         = 5,
   parameter int unsigned CODE_DISTANCE_Z         = 4,
   parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
   parameter int unsigned TIMEOUT_CYCLES          = 4096
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [2*CODE_DISTANCE_X*CODE_DISTANCE_Z*max_u(CODE_DISTANCE_X, CODE_DISTANCE_Z)-1:0] syn_data,
   input  logic                                 syn_valid,
   output logic                                 syn_ready,
   output logic [CODE_DISTANCE_X*CODE_DISTANCE_Z*max_u(CODE_DISTANCE_X, CODE_DISTANCE_Z)-1:0] left_is_error_syndromes,
   output logic [CODE_DISTANCE_X*CODE_DISTANCE_Z*max_u(CODE_DISTANCE_X, CODE_DISTANCE_Z)-1:0] right_is_error_syndromes,
   output logic                                 left_new_round_start,
   output logic                                 right_new_round_start,
   input  logic                                 left_result_valid,
   input  logic                                 right_result_valid,
   input  logic                                 left_deadlock,
   input  logic                                 right_deadlock,
   input  logic [ITERATION_COUNTER_WIDTH-1:0]   left_iteration_counter,
   input  logic [ITERATION_COUNTER_WIDTH-1:0]   right_iteration_counter,
   output logic                                 res_valid,
   input  logic                                 res_ready,
   output logic [STATUS_WIDTH-1:0]              res_status,
   output logic [ITERATION_COUNTER_WIDTH-1:0]   res_iterations,
   output logic [ROUND_ID_WIDTH-1:0]            res_round_id,
   output logic                                 busy
);

   localparam int unsigned MEASUREMENT_ROUNDS = max_u(CODE_DISTANCE_X, CODE_DISTANCE_Z);
   localparam int unsigned PU_COUNT           = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS;
   localparam int unsigned IW                 = ITERATION_COUNTER_WIDTH;

   sched_state_t                state_q, state_d;
   logic [PU_COUNT-1:0]         left_syn_q, left_syn_d, right_syn_q, right_syn_d;
   logic                        start_q, start_d;
   logic                        l_done_q, l_done_d, r_done_q, r_done_d;
   logic                        syn_ready_q, syn_ready_d;
   logic                        busy_q, busy_d;
   logic                        res_valid_q, res_valid_d;
   logic [STATUS_WIDTH-1:0]     status_q, status_d;
   logic [IW-1:0]               iter_q, iter_d;
   logic [ROUND_ID_WIDTH-1:0]   round_id_q, round_id_d;

   logic          wd_clear, wd_enable, wd_expired;
   logic          l_fin, r_fin, any_deadlock;
   logic [IW-1:0] iter_max;

   round_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_comb begin
      state_d      = state_q;
      left_syn_d   = left_syn_q;
      right_syn_d  = right_syn_q;
      start_d      = 1'b0;
      l_done_d     = l_done_q;
      r_done_d     = r_done_q;
      res_valid_d  = res_valid_q;
      status_d     = status_q;
      iter_d       = iter_q;
      round_id_d   = round_id_q;
      wd_clear     = 1'b0;
      wd_enable    = 1'b0;
      l_fin        = l_done_q | left_result_valid;
      r_fin        = r_done_q | right_result_valid;
      any_deadlock = left_deadlock | right_deadlock;
      iter_max     = (left_iteration_counter > right_iteration_counter) ?
                     left_iteration_counter : right_iteration_counter;

      case (state_q)
         IDLE: begin
            if (syn_valid && syn_ready_q) begin
               left_syn_d  = syn_data[PU_COUNT-1:0];
               right_syn_d = syn_data[2*PU_COUNT-1:PU_COUNT];
               start_d     = 1'b1;
               state_d     = START;
            end
         end
         START: begin
            l_done_d = 1'b0;
            r_done_d = 1'b0;
            wd_clear = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            wd_enable = 1'b1;
            l_done_d  = l_fin;
            r_done_d  = r_fin;
            // Deadlock outranks completion, which outranks the watchdog.
            if (any_deadlock || (l_fin && r_fin) || wd_expired) begin
               state_d     = REPORT;
               res_valid_d = 1'b1;
               iter_d      = iter_max;
               if (any_deadlock)        status_d = STATUS_DEADLOCK;
               else if (l_fin && r_fin) status_d = STATUS_OK;
               else                     status_d = STATUS_TIMEOUT;
            end
         end
         REPORT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               round_id_d  = round_id_q + ROUND_ID_WIDTH'(1);
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      syn_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         left_syn_q  <= '0;
         right_syn_q <= '0;
         start_q     <= 1'b0;
         l_done_q    <= 1'b0;
         r_done_q    <= 1'b0;
         syn_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         status_q    <= '0;
         iter_q      <= '0;
         round_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         left_syn_q  <= left_syn_d;
         right_syn_q <= right_syn_d;
         start_q     <= start_d;
         l_done_q    <= l_done_d;
         r_done_q    <= r_done_d;
         syn_ready_q <= syn_ready_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         status_q    <= status_d;
         iter_q      <= iter_d;
         round_id_q  <= round_id_d;
      end
   end

   assign syn_ready                = syn_ready_q;
   assign left_is_error_syndromes  = left_syn_q;
   assign right_is_error_syndromes = right_syn_q;
   assign left_new_round_start     = start_q;
   assign right_new_round_start    = start_q;
   assign res_valid                = res_valid_q;
   assign res_status               = status_q;
   assign res_iterations           = iter_q;
   assign res_round_id             = round_id_q;
   assign busy                     = busy_q;

endmodule

// File: tb/tb_decoder_round_scheduler.sv
// Directed bench for decoder_round_scheduler with a 16-cycle watchdog.
module tb_decoder_round_scheduler;

   localparam int unsigned PU = 100;

   logic          clk = 1'b0;
   logic          reset;
   logic [2*PU-1:0] syn_data;
   logic          syn_valid, syn_ready;
   logic [PU-1:0] left_syn, right_syn;
   logic          lnrs, rnrs;
   logic          lrv, rrv, ldl, rdl;
   logic [7:0]    liter, riter;
   logic          res_valid, res_ready, busy;
   logic [1:0]    res_status;
   logic [7:0]    res_iterations;
   logic [15:0]   res_round_id;

   int checks = 0;
   int errors = 0;
   int pulses;

   always #5 clk = ~clk;

   decoder_round_scheduler #(
      .CODE_DISTANCE_X(5), .CODE_DISTANCE_Z(4),
      .ITERATION_COUNTER_WIDTH(8), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset), .syn_data(syn_data), .syn_valid(syn_valid), .syn_ready(syn_ready),
      .left_is_error_syndromes(left_syn), .right_is_error_syndromes(right_syn),
      .left_new_round_start(lnrs), .right_new_round_start(rnrs),
      .left_result_valid(lrv), .right_result_valid(rrv),
      .left_deadlock(ldl), .right_deadlock(rdl),
      .left_iteration_counter(liter), .right_iteration_counter(riter),
      .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
      .res_iterations(res_iterations), .res_round_id(res_round_id), .busy(busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_frame(input logic [PU-1:0] l, input logic [PU-1:0] r);
      syn_data = {r, l};
   endtask

   // Handshake a frame and advance into the first WAIT cycle.
   task automatic launch();
      syn_valid = 1'b1;
      step();
      syn_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0; syn_valid = 1'b0; res_ready = 1'b0; set_frame('0, '0);
      lrv = 1'b0; rrv = 1'b0; ldl = 1'b0; rdl = 1'b0; liter = '0; riter = '0;
      repeat (3) step();
      reset = 1'b1;
      step();
      checks++; if (syn_ready !== 1'b1) begin errors++; $display("FAIL reset_syn_ready: got %b exp 1", syn_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (res_round_id !== 16'd0) begin errors++; $display("FAIL reset_round_id: got %0d exp 0", res_round_id); end
      checks++; if ({lnrs, rnrs} !== 2'b00) begin errors++; $display("FAIL reset_start: got %b exp 00", {lnrs, rnrs}); end
   endtask

   task automatic test_nominal();
      set_frame(PU'(1), PU'(2));
      liter = 8'd3; riter = 8'd7;
      syn_valid = 1'b1;
      step();
      syn_valid = 1'b0;
      checks++; if ({lnrs, rnrs} !== 2'b11) begin errors++; $display("FAIL nom_start: got %b exp 11", {lnrs, rnrs}); end
      checks++; if (left_syn !== PU'(1) || right_syn !== PU'(2)) begin errors++; $display("FAIL nom_syn: got l=%0h r=%0h exp l=1 r=2", left_syn, right_syn); end
      checks++; if ({syn_ready, busy} !== 2'b01) begin errors++; $display("FAIL nom_start_flags: got ready,busy=%b exp 01", {syn_ready, busy}); end
      step();
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         lrv = (k == 5);
         rrv = (k >= 9);
         pulses += int'(lnrs) + int'(rnrs);
         step();
         checks++; if (res_valid !== (k == 9)) begin errors++; $display("FAIL nom_res_valid_w%0d: got %b exp %b", k, res_valid, (k == 9)); end
      end
      lrv = 1'b0;
      checks++; if (pulses !== 0) begin errors++; $display("FAIL nom_extra_pulse: got %0d exp 0", pulses); end
      checks++; if (res_status !== 2'b00) begin errors++; $display("FAIL nom_status: got %b exp 00", res_status); end
      checks++; if (res_iterations !== 8'd7) begin errors++; $display("FAIL nom_iter: got %0d exp 7", res_iterations); end
      checks++; if (res_round_id !== 16'd0) begin errors++; $display("FAIL nom_round_id: got %0d exp 0", res_round_id); end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0; rrv = 1'b0;
      checks++; if ({res_valid, syn_ready, busy} !== 3'b010) begin errors++; $display("FAIL nom_idle: got valid,ready,busy=%b exp 010", {res_valid, syn_ready, busy}); end
      checks++; if (res_round_id !== 16'd1) begin errors++; $display("FAIL nom_round_inc: got %0d exp 1", res_round_id); end
   endtask

   task automatic test_deadlock();
      liter = 8'd4; riter = 8'd9;
      launch();
      for (int k = 0; k < 3; k++) begin
         rdl = (k == 2);
         lrv = (k == 2);
         step();
         checks++; if (res_valid !== (k == 2)) begin errors++; $display("FAIL dl_res_valid_w%0d: got %b exp %b", k, res_valid, (k == 2)); end
      end
      rdl = 1'b0; lrv = 1'b0;
      checks++; if (res_status !== 2'b01) begin errors++; $display("FAIL dl_status: got %b exp 01", res_status); end
      checks++; if (res_iterations !== 8'd9) begin errors++; $display("FAIL dl_iter: got %0d exp 9", res_iterations); end
      checks++; if (res_round_id !== 16'd1) begin errors++; $display("FAIL dl_round_id: got %0d exp 1", res_round_id); end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      step();
      checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL dl_single_report: got valid,busy=%b exp 00", {res_valid, busy}); end
   endtask

   task automatic test_timeout();
      liter = 8'd2; riter = 8'd1;
      launch();
      for (int k = 0; k < 16; k++) begin
         step();
         checks++; if (res_valid !== (k == 15)) begin errors++; $display("FAIL to_res_valid_w%0d: got %b exp %b", k + 1, res_valid, (k == 15)); end
      end
      checks++; if (res_status !== 2'b10) begin errors++; $display("FAIL to_status: got %b exp 10", res_status); end
      checks++; if (res_iterations !== 8'd2) begin errors++; $display("FAIL to_iter: got %0d exp 2", res_iterations); end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      checks++; if (res_round_id !== 16'd3) begin errors++; $display("FAIL to_round_inc: got %0d exp 3", res_round_id); end
   endtask

   task automatic test_backpressure();
      liter = 8'd5; riter = 8'd6;
      set_frame(PU'(3), PU'(4));
      launch();
      lrv = 1'b1; rrv = 1'b1;
      step();
      lrv = 1'b0; rrv = 1'b0;
      set_frame(PU'(5), PU'(6));
      syn_valid = 1'b1;
      liter = 8'hAA; riter = 8'hBB;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         pulses += int'(lnrs) + int'(rnrs);
         checks++;
         if ({res_valid, syn_ready, res_status, res_iterations, res_round_id} !== {1'b1, 1'b0, 2'b00, 8'd6, 16'd3}) begin
            errors++;
            $display("FAIL bp_hold_c%0d: got v=%b rdy=%b st=%b it=%0d id=%0d exp v=1 rdy=0 st=00 it=6 id=3",
                     k, res_valid, syn_ready, res_status, res_iterations, res_round_id);
         end
         step();
      end
      checks++; if (pulses !== 0 || left_syn !== PU'(3)) begin errors++; $display("FAIL bp_no_start: got pulses=%0d lsyn=%0h exp 0,3", pulses, left_syn); end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      checks++; if ({res_valid, syn_ready} !== 2'b01 || res_round_id !== 16'd4) begin errors++; $display("FAIL bp_release: got v,rdy=%b id=%0d exp 01 id=4", {res_valid, syn_ready}, res_round_id); end
      step();
      syn_valid = 1'b0;
      checks++; if ({lnrs, rnrs} !== 2'b11 || left_syn !== PU'(5) || right_syn !== PU'(6)) begin errors++; $display("FAIL bp_next_frame: got start=%b l=%0h r=%0h exp 11 5 6", {lnrs, rnrs}, left_syn, right_syn); end
   endtask

   task automatic test_reset_mid_wait();
      step();
      step();
      reset = 1'b0; lrv = 1'b1; rrv = 1'b1;
      step();
      reset = 1'b1;
      checks++; if ({busy, syn_ready, res_valid, lnrs} !== 4'b0100) begin errors++; $display("FAIL rst_flags: got busy,rdy,v,start=%b exp 0100", {busy, syn_ready, res_valid, lnrs}); end
      checks++; if (res_round_id !== 16'd0 || res_status !== 2'b00 || res_iterations !== 8'd0) begin errors++; $display("FAIL rst_fields: got id=%0d st=%b it=%0d exp 0 00 0", res_round_id, res_status, res_iterations); end
      checks++; if (left_syn !== '0 || right_syn !== '0) begin errors++; $display("FAIL rst_syn: got l=%0h r=%0h exp 0 0", left_syn, right_syn); end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL rst_stale_c%0d: got v,busy=%b exp 00", k, {res_valid, busy}); end
      end
      lrv = 1'b0; rrv = 1'b0;
      liter = 8'd1; riter = 8'd0;
      launch();
      lrv = 1'b1; rrv = 1'b1;
      step();
      lrv = 1'b0; rrv = 1'b0;
      checks++; if ({res_valid, res_status, res_round_id} !== {1'b1, 2'b00, 16'd0}) begin errors++; $display("FAIL rst_min_latency: got v=%b st=%b id=%0d exp 1 00 0", res_valid, res_status, res_round_id); end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_deadlock();
      test_timeout();
      test_backpressure();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
